pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Owns the MIPS program counter and sequences the single shared 32-bit adder between two users:
//  sequential increment (PC+4) and branch-target calculation (PC+(off<<2)). Drives instruction
//  fetch over a req/ack handshake, presents fetched words to decode over valid/ready, and applies
//  branch/jump redirects after exactly one delay-slot instruction. Sits between imem and decode.
// PARAMETERS
//  RESET_VEC  32'hBFC0_0000  PC loaded on reset
//  EXC_VEC    32'h8000_0180  PC loaded on exception (used only with PC_SEQ_EXC_EN)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  if_req       out  1   fetch request; held with if_addr stable until if_ack
//  if_addr      out  32  fetch address (= pc)
//  if_ack       in   1   fetch complete; if_rdata valid this cycle
//  if_rdata     in   32  fetched instruction
//  id_valid     out  1   instruction available to decode
//  id_ready     in   1   decode accepts; handoff when id_valid && id_ready
//  id_instr     out  32  instruction word
//  id_pc        out  32  address of id_instr
//  br_valid     in   1   taken branch, for the most recently handed-off instruction (1-cycle pulse)
//  br_offset    in   16  signed word offset of the branch
//  jmp_valid    in   1   jump, same timing as br_valid
//  jmp_index    in   26  jump instr_index
//  exc_req      in   1   exception redirect pulse (present only with PC_SEQ_EXC_EN)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, pc=RESET_VEC, if_req=0, id_valid=0, id_instr=0, id_pc=0,
//   redirect state cleared. if_addr=pc, so it reads RESET_VEC during reset.
//  FSM: IDLE -(1 cyc)-> FETCH -(if_ack)-> HOLD -(handoff)-> INCR -(1 cyc)-> FETCH.
//   FETCH: if_req=1. On if_ack: id_instr<=if_rdata, id_pc<=pc, go HOLD.
//   HOLD : id_valid=1. Wait for id_ready; handoff clears id_valid next cycle.
//   INCR : pc <= tgt_vld ? tgt_q : adder(pc,4); clear tgt_vld/redir_pend.
//  Min throughput: 1 instr per 3 cycles (FETCH, HOLD, INCR) with immediate ack/ready.
//  Adder arbitration: INCR owns the adder (A=pc, B=32'd4). In every other state the adder is
//   A=pc, B=sext32(off)<<2, where off=br_offset if br_valid else off_q.
//  Redirect capture: br_valid/jmp_valid are legal in INCR, FETCH, HOLD; at the latest in the
//   cycle the delay slot is handed off.
//   In INCR: capture off_q/jmp kind, set redir_pend. pc is still the branch PC, so no target yet.
//   In FETCH/HOLD: pc = delay-slot PC, so compute and store tgt_q, set tgt_vld the same cycle.
//   Pending (redir_pend && !tgt_vld) and FETCH/HOLD: compute tgt_q from off_q.
//   Jump target = {pc[31:28], jmp_index, 2'b00}; no adder needed.
//  The next INCR after capture (the delay-slot handoff) loads tgt_q. The delay slot always executes.
//  br_valid && jmp_valid together: jump wins. New redirect while one is pending: ignored.
//   Both cases also raise an assertion.
//  Arithmetic: modulo 2^32, so 32'hFFFF_FFFC+4 -> 0. Offset sign-extended before <<2.
//  if_req/if_addr never change while if_req=1 and !if_ack.
// CONFIGURATION
//  PC_SEQ_EXC_EN defined:
//   - exc_req port exists; exc_req is latched in any state.
//   - Outside FETCH: next cycle pc<=EXC_VEC, id_valid<=0, redirect state cleared, go FETCH.
//   - In FETCH with a request outstanding: wait for if_ack, discard if_rdata, then redirect.
//   - exc_req overrides a same-cycle br/jmp.
//  Undefined: no exc_req port; EXC_VEC unused; no exception path logic.
// STRUCTURE
//  Package pc_seq_pkg: pc_state_e {IDLE,FETCH,HOLD,INCR}, PC_INC=32'd4, sext_off() function.
//  One sub-instance: the team's 32-bit combinational adder `adder`, operand muxes in this block.
//  Everything else lives in this module.
// TESTING
//  1. Reset, ack/ready immediate: if_addr BFC00000, BFC00004, BFC00008 at 3-cycle spacing.
//  2. if_ack delayed 4 cycles, id_ready delayed 3 cycles: if_addr stable, no duplicate handoff.
//  3. Branch at pc=0x100, off=16'hFFFC, br_valid in INCR:
//     handoffs 0x100, 0x104 (delay slot), then 0xF4.
//  4. Jump at pc=0x9000_0010, jmp_index=26'h40, br in HOLD at delay-slot handoff:
//     next fetch 0x9000_0100.
//  5. pc=32'hFFFF_FFFC handoff -> next if_addr 0x0. Async reset mid-HOLD: id_valid=0 at once,
//     next fetch RESET_VEC.
//  6. (PC_SEQ_EXC_EN) exc_req during outstanding fetch at 0x200: ack data dropped,
//     next fetch 0x8000_0180, pending branch cancelled.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, INCR} pc_state_e;

  localparam logic [31:0] PC_INC = 32'd4;

  // Sign-extend a 16-bit word offset and scale it to a byte offset.
  function automatic logic [31:0] sext_off(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_adder.sv
// Shared 32-bit combinational adder (modulo 2^32).
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// MIPS PC sequencer: fetch handshake, decode handoff, delayed branch/jump redirect.
// Optional exception redirect to EXC_VEC when PC_SEQ_EXC_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ack,
  input  logic [31:0] if_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        br_valid,
  input  logic [15:0] br_offset,
  input  logic        jmp_valid,
`ifdef PC_SEQ_EXC_EN
  input  logic        exc_req,
`endif
  input  logic [25:0] jmp_index
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [15:0] off_q, off_d;
  logic        jmp_q, jmp_d;
  logic [25:0] jidx_q, jidx_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic        tgt_vld_q, tgt_vld_d;

  logic [31:0] add_b, add_sum, jmp_tgt;
  logic        new_redir, jmp_now;
  logic [25:0] jidx_now;

  // INCR owns the adder; otherwise it computes branch targets.
  assign add_b = (state_q == INCR) ? PC_INC : sext_off(br_valid ? br_offset : off_q);

  adder u_adder (
    .a   (pc_q),
    .b   (add_b),
    .sum (add_sum)
  );

  assign new_redir = (br_valid || jmp_valid) && !(redir_pend_q || tgt_vld_q);
  assign jmp_now   = new_redir ? jmp_valid : jmp_q;
  assign jidx_now  = new_redir ? jmp_index : jidx_q;
  assign jmp_tgt   = {pc_q[31:28], jidx_now, 2'b00};

  assign if_req   = (state_q == FETCH);
  assign if_addr  = pc_q;
  assign id_valid = (state_q == HOLD);
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;

`ifdef PC_SEQ_EXC_EN
  logic exc_pend_q, exc_pend_d;
`else
  logic [31:0] unused_exc_vec;
  assign unused_exc_vec = EXC_VEC;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    off_d        = off_q;
    jmp_d        = jmp_q;
    jidx_d       = jidx_q;
    redir_pend_d = redir_pend_q;
    tgt_d        = tgt_q;
    tgt_vld_d    = tgt_vld_q;

    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (if_ack) begin
          id_instr_d = if_rdata;
          id_pc_d    = pc_q;
          state_d    = HOLD;
        end
      end
      HOLD:  if (id_ready) state_d = INCR;
      INCR: begin
        pc_d         = tgt_vld_q ? tgt_q : add_sum;
        tgt_vld_d    = 1'b0;
        redir_pend_d = 1'b0;
        state_d      = FETCH;
      end
      default: state_d = IDLE;
    endcase

    // In INCR pc is still the branch PC, so only remember the redirect.
    if (state_q == INCR) begin
      if (new_redir) begin
        off_d        = br_offset;
        jmp_d        = jmp_valid;
        jidx_d       = jmp_index;
        redir_pend_d = 1'b1;
      end
    end else if (new_redir || (redir_pend_q && !tgt_vld_q)) begin
      tgt_d     = jmp_now ? jmp_tgt : add_sum;
      tgt_vld_d = 1'b1;
    end

`ifdef PC_SEQ_EXC_EN
    exc_pend_d = exc_pend_q;
    if (exc_req || exc_pend_q) begin
      if (state_q == FETCH && !if_ack) begin
        exc_pend_d = 1'b1;
      end else begin
        // Drop any fetched word and all redirect state.
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        pc_d         = EXC_VEC;
        state_d      = FETCH;
        tgt_vld_d    = 1'b0;
        redir_pend_d = 1'b0;
        exc_pend_d   = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VEC;
      id_instr_q   <= '0;
      id_pc_q      <= '0;
      off_q        <= '0;
      jmp_q        <= 1'b0;
      jidx_q       <= '0;
      redir_pend_q <= 1'b0;
      tgt_q        <= '0;
      tgt_vld_q    <= 1'b0;
`ifdef PC_SEQ_EXC_EN
      exc_pend_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      off_q        <= off_d;
      jmp_q        <= jmp_d;
      jidx_q       <= jidx_d;
      redir_pend_q <= redir_pend_d;
      tgt_q        <= tgt_d;
      tgt_vld_q    <= tgt_vld_d;
`ifdef PC_SEQ_EXC_EN
      exc_pend_q   <= exc_pend_d;
`endif
    end
  end

  // Decode must never signal branch and jump together, nor stack redirects.
  assert property (@(posedge clk) disable iff (!rst_n) !(br_valid && jmp_valid));
  assert property (@(posedge clk) disable iff (!rst_n)
                   (br_valid || jmp_valid) |-> !(redir_pend_q || tgt_vld_q));
  assert property (@(posedge clk) disable iff (!rst_n)
                   (if_req && !if_ack) |=> (if_req && $stable(if_addr)));

endmodule
